// File: rtl/median_bbox_stats_if.sv
// Result-write port of the median filter plus the frame result record.
// master = filter/controller side (drives strobes), slave = stats block.
// Flow control is a held-result/acknowledge handshake on resultValid/resultAck.
interface median_bbox_stats_if #(
  parameter int ADDR_W = 8,
  parameter int CNT_W  = 16
);
  logic              init;
  logic              writeMedianMem;
  logic              writeMedianData;
  logic [ADDR_W-1:0] xAddressIn;
  logic [ADDR_W-1:0] yAddressIn;
  logic              fullImageDone;
  logic              resultAck;
  logic              resultValid;
  logic              objectPresent;
  logic [CNT_W-1:0]  pixelCount;
  logic [ADDR_W-1:0] xMin;
  logic [ADDR_W-1:0] xMax;
  logic [ADDR_W-1:0] yMin;
  logic [ADDR_W-1:0] yMax;
  logic              addrError;
  logic              busy;

  modport master (
    output init, writeMedianMem, writeMedianData, xAddressIn, yAddressIn,
           fullImageDone, resultAck,
    input  resultValid, objectPresent, pixelCount, xMin, xMax, yMin, yMax,
           addrError, busy
  );

  modport slave (
    input  init, writeMedianMem, writeMedianData, xAddressIn, yAddressIn,
           fullImageDone, resultAck,
    output resultValid, objectPresent, pixelCount, xMin, xMax, yMin, yMax,
           addrError, busy
  );
endinterface

// File: rtl/median_bbox_stats.sv
// Per-frame set-pixel count and bounding box of the median filter output.
// Latency: result valid one cycle after the fullImageDone rising edge.
// Backpressure: result held in DONE until resultAck; writes ignored meanwhile.
module median_bbox_stats #(
  parameter int IMG_WIDTH  = 240,
  parameter int IMG_HEIGHT = 180,
  parameter int ADDR_W     = 8,
  parameter int CNT_W      = 16,
  parameter int MIN_PIXELS = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  median_bbox_stats_if.slave    bus
);

  localparam logic [ADDR_W:0]  LP_W   = (ADDR_W+1)'(IMG_WIDTH);
  localparam logic [ADDR_W:0]  LP_H   = (ADDR_W+1)'(IMG_HEIGHT);
  localparam logic [CNT_W-1:0] LP_MIN = CNT_W'(MIN_PIXELS);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic              r_fid_d;

  // running accumulators
  logic [CNT_W-1:0]  r_cnt;
  logic [ADDR_W-1:0] r_xmin, r_xmax, r_ymin, r_ymax;
  logic [CNT_W-1:0]  w_cnt_nxt;
  logic [ADDR_W-1:0] w_xmin_nxt, w_xmax_nxt, w_ymin_nxt, w_ymax_nxt;

  // latched result record
  logic              r_valid;
  logic              r_obj;
  logic [CNT_W-1:0]  r_pix_cnt;
  logic [ADDR_W-1:0] r_oxmin, r_oxmax, r_oymin, r_oymax;
  logic              r_addr_err;

  logic              w_in_range;
  logic              w_wr_accum;
  logic              w_hit;
  logic              w_bad;
  logic              w_frame_end;
  logic              w_empty;

  assign w_in_range  = ({1'b0, bus.xAddressIn} < LP_W) && ({1'b0, bus.yAddressIn} < LP_H);
  assign w_wr_accum  = (r_state == ST_ACCUM) && bus.writeMedianMem;
  assign w_hit       = w_wr_accum && w_in_range && bus.writeMedianData;
  assign w_bad       = w_wr_accum && !w_in_range;
  // init outranks the frame edge: a clearing init must not also publish a result
  assign w_frame_end = (r_state == ST_ACCUM) && bus.fullImageDone && !r_fid_d && !bus.init;
  assign w_empty     = (w_cnt_nxt == '0);

  // next-state accumulator values, so a write on the edge cycle is counted
  always_comb begin
    w_cnt_nxt  = r_cnt;
    w_xmin_nxt = r_xmin;
    w_xmax_nxt = r_xmax;
    w_ymin_nxt = r_ymin;
    w_ymax_nxt = r_ymax;
    if (w_hit) begin
      if (r_cnt != '1) w_cnt_nxt = r_cnt + CNT_W'(1);
      if (bus.xAddressIn < r_xmin) w_xmin_nxt = bus.xAddressIn;
      if (bus.xAddressIn > r_xmax) w_xmax_nxt = bus.xAddressIn;
      if (bus.yAddressIn < r_ymin) w_ymin_nxt = bus.yAddressIn;
      if (bus.yAddressIn > r_ymax) w_ymax_nxt = bus.yAddressIn;
    end
  end

  // FSM next state; init wins over every other event
  always_comb begin
    w_state_nxt = r_state;
    if (bus.init) begin
      w_state_nxt = ST_ACCUM;
    end else begin
      case (r_state)
        ST_IDLE:  w_state_nxt = ST_IDLE;
        ST_ACCUM: if (w_frame_end) w_state_nxt = ST_DONE;
        ST_DONE:  if (bus.resultAck) w_state_nxt = ST_IDLE;
        default:  w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // FSM state register and fullImageDone delay for edge detection
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_fid_d <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_fid_d <= bus.fullImageDone;
    end
  end

  // accumulators: cleared by reset/init, updated only while accumulating
  always_ff @(posedge clk) begin
    if (reset || bus.init) begin
      r_cnt  <= '0;
      r_xmin <= '1;
      r_xmax <= '0;
      r_ymin <= '1;
      r_ymax <= '0;
    end else if (r_state == ST_ACCUM) begin
      r_cnt  <= w_cnt_nxt;
      r_xmin <= w_xmin_nxt;
      r_xmax <= w_xmax_nxt;
      r_ymin <= w_ymin_nxt;
      r_ymax <= w_ymax_nxt;
    end
  end

  // sticky out-of-range flag for the current frame
  always_ff @(posedge clk) begin
    if (reset || bus.init) begin
      r_addr_err <= 1'b0;
    end else if (w_bad) begin
      r_addr_err <= 1'b1;
    end
  end

  // result record: loaded at frame end, data retained across ack/init
  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid   <= 1'b0;
      r_obj     <= 1'b0;
      r_pix_cnt <= '0;
      r_oxmin   <= '0;
      r_oxmax   <= '0;
      r_oymin   <= '0;
      r_oymax   <= '0;
    end else if (bus.init) begin
      r_valid <= 1'b0;
    end else if (w_frame_end) begin
      r_valid   <= 1'b1;
      r_obj     <= (w_cnt_nxt >= LP_MIN);
      r_pix_cnt <= w_cnt_nxt;
      // empty frame reports a zero box rather than the min/max sentinels
      r_oxmin   <= w_empty ? '0 : w_xmin_nxt;
      r_oxmax   <= w_empty ? '0 : w_xmax_nxt;
      r_oymin   <= w_empty ? '0 : w_ymin_nxt;
      r_oymax   <= w_empty ? '0 : w_ymax_nxt;
    end else if ((r_state == ST_DONE) && bus.resultAck) begin
      r_valid <= 1'b0;
    end
  end

  assign bus.resultValid   = r_valid;
  assign bus.objectPresent = r_obj;
  assign bus.pixelCount    = r_pix_cnt;
  assign bus.xMin          = r_oxmin;
  assign bus.xMax          = r_oxmax;
  assign bus.yMin          = r_oymin;
  assign bus.yMax          = r_oymax;
  assign bus.addrError     = r_addr_err;
  assign bus.busy          = (r_state == ST_ACCUM);

endmodule

// File: tb/tb_median_bbox_stats.sv
// Directed bench for median_bbox_stats: bounding box, count, edge cases.
// Inputs change 1ns after the rising edge; outputs checked at the same point.
// The result handshake is exercised explicitly via resultAck.
module tb_median_bbox_stats;
  logic clk;
  logic reset;
  int   checks;
  int   errors;

  median_bbox_stats_if #(.ADDR_W(8), .CNT_W(16)) bus ();

  median_bbox_stats #(
    .IMG_WIDTH(240), .IMG_HEIGHT(180), .ADDR_W(8), .CNT_W(16), .MIN_PIXELS(16)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic wr(input int x, input int y, input logic d);
    bus.writeMedianMem  = 1'b1;
    bus.writeMedianData = d;
    bus.xAddressIn      = 8'(x);
    bus.yAddressIn      = 8'(y);
    tick();
    bus.writeMedianMem  = 1'b0;
    bus.writeMedianData = 1'b0;
  endtask

  task automatic pulse_init();
    bus.init = 1'b1;
    tick();
    bus.init = 1'b0;
  endtask

  task automatic pulse_fid();
    bus.fullImageDone = 1'b1;
    tick();
    bus.fullImageDone = 1'b0;
  endtask

  task automatic chk_result(input string tag, input int cnt, input int x0, input int x1,
                            input int y0, input int y1, input logic op);
    chk({tag, ".valid"}, 32'(bus.resultValid), 32'd1);
    chk({tag, ".cnt"},   32'(bus.pixelCount), 32'(cnt));
    chk({tag, ".xmin"},  32'(bus.xMin), 32'(x0));
    chk({tag, ".xmax"},  32'(bus.xMax), 32'(x1));
    chk({tag, ".ymin"},  32'(bus.yMin), 32'(y0));
    chk({tag, ".ymax"},  32'(bus.yMax), 32'(y1));
    chk({tag, ".obj"},   32'(bus.objectPresent), 32'(op));
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    bus.init = 1'b0; bus.writeMedianMem = 1'b0; bus.writeMedianData = 1'b0;
    bus.xAddressIn = '0; bus.yAddressIn = '0; bus.fullImageDone = 1'b0; bus.resultAck = 1'b0;
    tick();
    tick();
    reset = 1'b0;

    // reset state
    chk("rst.valid", 32'(bus.resultValid), 32'd0);
    chk("rst.cnt",   32'(bus.pixelCount), 32'd0);
    chk("rst.xmin",  32'(bus.xMin), 32'd0);
    chk("rst.busy",  32'(bus.busy), 32'd0);
    chk("rst.aerr",  32'(bus.addrError), 32'd0);
    chk("rst.obj",   32'(bus.objectPresent), 32'd0);

    // 1: three scattered pixels
    pulse_init();
    chk("t1.busy", 32'(bus.busy), 32'd1);
    wr(10, 20, 1'b1);
    wr(200, 5, 1'b1);
    wr(37, 170, 1'b1);
    pulse_fid();
    chk_result("t1", 3, 10, 200, 5, 170, 1'b0);
    chk("t1.busy_done", 32'(bus.busy), 32'd0);

    // 2: full raster of ones
    pulse_init();
    chk("t2.valid_clr", 32'(bus.resultValid), 32'd0);
    chk("t2.cnt_kept",  32'(bus.pixelCount), 32'd3);
    for (int y = 0; y < 180; y++)
      for (int x = 0; x < 240; x++)
        wr(x, y, 1'b1);
    pulse_fid();
    chk_result("t2", 43200, 0, 239, 0, 179, 1'b1);
    chk("t2.aerr", 32'(bus.addrError), 32'd0);

    // 3: empty frame, then acknowledge
    pulse_init();
    for (int i = 0; i < 10; i++) wr(i * 7, i * 3, 1'b0);
    pulse_fid();
    chk_result("t3", 0, 0, 0, 0, 0, 1'b0);
    bus.resultAck = 1'b1;
    tick();
    bus.resultAck = 1'b0;
    chk("t3.valid_ack", 32'(bus.resultValid), 32'd0);
    chk("t3.busy_ack",  32'(bus.busy), 32'd0);
    bus.resultAck = 1'b1;          // ack in IDLE is a no-op
    tick();
    bus.resultAck = 1'b0;
    chk("t3.busy_idle_ack", 32'(bus.busy), 32'd0);

    // 4: out-of-range addresses
    pulse_init();
    wr(240, 0, 1'b1);
    chk("t4.aerr_live", 32'(bus.addrError), 32'd1);
    wr(5, 180, 1'b1);
    wr(3, 4, 1'b1);
    pulse_fid();
    chk_result("t4", 1, 3, 3, 4, 4, 1'b0);
    chk("t4.aerr", 32'(bus.addrError), 32'd1);
    pulse_init();
    chk("t4.aerr_clr", 32'(bus.addrError), 32'd0);
    chk("t4.busy", 32'(bus.busy), 32'd1);

    // 5: write coincident with the edge, writes in DONE, fid held across init
    bus.writeMedianMem = 1'b1; bus.writeMedianData = 1'b1;
    bus.xAddressIn = 8'd100; bus.yAddressIn = 8'd100;
    bus.fullImageDone = 1'b1;
    tick();
    bus.writeMedianMem = 1'b0; bus.writeMedianData = 1'b0;
    chk_result("t5", 1, 100, 100, 100, 100, 1'b0);
    wr(7, 7, 1'b1);
    chk("t5.done_cnt",  32'(bus.pixelCount), 32'd1);
    chk("t5.done_xmin", 32'(bus.xMin), 32'd100);
    // init with simultaneous ack: init wins, fid still high
    bus.init = 1'b1; bus.resultAck = 1'b1;
    tick();
    bus.init = 1'b0; bus.resultAck = 1'b0;
    chk("t5.init_valid", 32'(bus.resultValid), 32'd0);
    chk("t5.init_busy",  32'(bus.busy), 32'd1);
    tick();
    tick();
    chk("t5.held_noedge", 32'(bus.resultValid), 32'd0);
    wr(50, 60, 1'b1);
    bus.fullImageDone = 1'b0;
    tick();
    chk("t5.fall_noedge", 32'(bus.resultValid), 32'd0);
    pulse_fid();
    chk_result("t5b", 1, 50, 50, 60, 60, 1'b0);

    // 6: reset mid-frame
    pulse_init();
    for (int i = 0; i < 50; i++) wr(i, 1, 1'b1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("t6.valid", 32'(bus.resultValid), 32'd0);
    chk("t6.cnt",   32'(bus.pixelCount), 32'd0);
    chk("t6.xmax",  32'(bus.xMax), 32'd0);
    chk("t6.busy",  32'(bus.busy), 32'd0);
    wr(5, 5, 1'b1);
    pulse_fid();
    chk("t6.idle_valid", 32'(bus.resultValid), 32'd0);
    chk("t6.idle_cnt",   32'(bus.pixelCount), 32'd0);
    tick();
    pulse_init();
    pulse_fid();
    chk_result("t6b", 0, 0, 0, 0, 0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/median_bbox_stats.md
Name: median_bbox_stats

Overview:
- Downstream consumer of the median filter core; sits on its result-write port (write strobe, filtered bit, x/y address, frame-done).
- Per frame: counts set filtered pixels and tracks the bounding box (x/y min/max) of the set pixels.
- At end of frame, latches a result record and holds it until acknowledged.
- Result feeds the wake-up / object-detect logic; no image memory is needed.

Parameters:
- IMG_WIDTH, 240, pixel columns; valid x range 0..IMG_WIDTH-1.
- IMG_HEIGHT, 180, pixel rows; valid y range 0..IMG_HEIGHT-1.
- ADDR_W, 8, x/y address width.
- CNT_W, 16, pixel counter width (saturating).
- MIN_PIXELS, 16, minimum set-pixel count for objectPresent.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- init  in  1  one-cycle pulse; clears accumulators, enters ACCUM.
- writeMedianMem  in  1  write strobe from the median filter.
- writeMedianData  in  1  filtered pixel bit, qualified by writeMedianMem.
- xAddressIn  in  ADDR_W  column of the current write.
- yAddressIn  in  ADDR_W  row of the current write.
- fullImageDone  in  1  level or pulse from the filter; rising edge ends the frame.
- resultAck  in  1  consumer acknowledge of the held result.
- resultValid  out  1  result record valid.
- objectPresent  out  1  pixelCount >= MIN_PIXELS.
- pixelCount  out  CNT_W  set-pixel count.
- xMin, xMax, yMin, yMax  out  ADDR_W  each  bounding box.
- addrError  out  1  sticky flag: an out-of-range address was seen this frame.
- busy  out  1  high in ACCUM.

Behaviour:
- Single clock domain. All registers update on the clk rising edge. reset is synchronous, active-high.
- Reset values:
  - State = IDLE.
  - All outputs 0.
  - Internal accumulators: count 0, xMin/yMin = all-ones, xMax/yMax = 0.
  - Edge-detect register for fullImageDone = 0.
- States:
  - IDLE: writes are ignored. init -> ACCUM.
  - ACCUM: busy=1. Accumulates writes. Rising edge of fullImageDone -> DONE.
  - DONE: holds the result. resultAck -> IDLE.
- init has priority in every state:
  - Next cycle: state ACCUM, accumulators cleared, resultValid=0, addrError=0.
  - Latched outputs other than resultValid keep their values.
- Accumulate rule (ACCUM, writeMedianMem=1):
  - If x >= IMG_WIDTH or y >= IMG_HEIGHT: write ignored, addrError set.
  - Else if writeMedianData=1:
    - count = count+1, saturating at 2^CNT_W-1.
    - xMin = min(xMin, x), xMax = max(xMax, x).
    - yMin = min(yMin, y), yMax = max(yMax, y).
  - writeMedianData=0 writes change nothing.
- End of frame:
  - Frame end is fullImageDone high while the delayed copy is low, in ACCUM.
  - On the next cycle:
    - resultValid=1.
    - Output registers load the accumulator values.
    - A write arriving in the same cycle as the edge IS included (use next-state accumulator values).
  - Latency: one cycle from the edge to resultValid.
- Empty frame (count=0): pixelCount=0, objectPresent=0, xMin=xMax=yMin=yMax=0. The all-ones sentinel never appears on outputs.
- objectPresent is registered with the result and computed from the final count.
- DONE:
  - Writes and further fullImageDone edges are ignored.
  - Outputs stable until resultAck (1 cycle) -> resultValid=0 next cycle, state IDLE, data outputs retained.
  - resultAck outside DONE is ignored.
- init and resultAck in the same cycle: init wins.
- fullImageDone held high across a following init: no new edge, so the frame does not end until fullImageDone falls and rises again.
- Reset mid-frame: accumulators and outputs return to reset values, state IDLE.

Test Plan:
1. Reset, init, then writes with data=1 at (10,20), (200,5), (37,170); fullImageDone pulse -> one cycle later resultValid=1, pixelCount=3, xMin=10, xMax=200, yMin=5, yMax=170, objectPresent=0.
2. Full 240x180 raster of ones (43200 writes), fullImageDone -> pixelCount=43200, bbox 0/239/0/179, objectPresent=1, addrError=0.
3. Empty frame (all data=0) -> pixelCount=0, bbox all 0, objectPresent=0. Then resultAck -> resultValid=0 next cycle, busy=0.
4. Write (240,0) data=1 and (5,180) data=1, plus (3,4) data=1 -> addrError=1, pixelCount=1, bbox 3/3/4/4. A new init clears addrError.
5. Write (100,100) data=1 in the same cycle as the fullImageDone rise -> pixelCount=1, xMin=xMax=100. Writes in DONE leave outputs unchanged. fullImageDone held high then init -> no spurious result until a new rising edge.
6. Reset asserted mid-frame after 50 set pixels -> all outputs 0, state IDLE. A following write without init is ignored (pixelCount stays 0 after the next frame-done).
